// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage for the multi-cycle MIPS core. Issues one instruction-memory
// read at a time, latches the returned word into the instruction register
// (IR) and presents it to decode over a valid/ready handshake. PC redirects
// from branch/jump resolution discard any fetch still in flight.
//
// Optional feature macro: IFU_PERF_CNT_EN
//   When defined, adds fetch_count / flush_count performance counters.
//
// Parameters
//   ADDR_W    width of PC and memory address
//   RESET_PC  PC loaded on reset (low 2 bits must be 0)
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   imem_req/addr     read request (held until granted) and word address
//   imem_gnt          request accepted when imem_req && imem_gnt
//   imem_rvalid/rdata read response, at least one cycle after grant
//   instr_valid       IR holds an instruction for decode
//   instr_ready       decode accepts the instruction this cycle
//   instr/opcode      IR contents and its [31:26] field
//   instr_pc          address the IR was fetched from
//   redirect_valid/pc branch taken or jump; new PC (low bits ignored)
//   fetch_count       (optional) accepted instructions
//   flush_count       (optional) redirect cycles outside S_IDLE
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | just out of reset; moves to S_REQ on the first clock edge
// S_REQ   | imem_req high at pc, waiting for grant
// S_WAIT  | request granted, waiting for rvalid
// S_FLUSH | granted request was redirected; drop its response
// S_HOLD  | IR valid, waiting for decode to accept
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       flush_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_FLUSH = 3'd3,
        S_HOLD  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [ADDR_W-1:0] redirect_tgt;

    // Targets are forced word-aligned; masking keeps every input bit in use.
    assign redirect_tgt = redirect_pc & ~ADDR_W'(3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_valid) pc_d = redirect_tgt;
            end
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    // A granted but redirected request still returns data.
                    if (imem_gnt) state_d = S_FLUSH;
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = imem_rvalid ? S_REQ : S_FLUSH;
                end else if (imem_rvalid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = S_HOLD;
                end
            end
            S_FLUSH: begin
                if (redirect_valid) pc_d = redirect_tgt;
                if (imem_rvalid) state_d = S_REQ;
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = S_REQ;
                end else if (instr_ready) begin
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs come only from registered state, pc and IR.
    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_HOLD);
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_pc    = instr_pc_q;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q == S_HOLD) && instr_ready && !redirect_valid)
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (redirect_valid && (state_q != S_IDLE))
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point, away from the edge.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .opcode         (opcode),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .flush_count    (flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Outputs expected while the fetch unit sits in S_REQ at a given address.
    task automatic chk_req(input string tag, input logic [31:0] addr);
        chk({tag, ".req"}, {31'b0, imem_req}, 32'd1);
        chk({tag, ".addr"}, imem_addr, addr);
        chk({tag, ".valid"}, {31'b0, instr_valid}, 32'd0);
    endtask

    task automatic chk_hold(input string tag, input logic [31:0] ir, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'b0, instr_valid}, 32'd1);
        chk({tag, ".req"}, {31'b0, imem_req}, 32'd0);
        chk({tag, ".instr"}, instr, ir);
        chk({tag, ".opcode"}, {26'b0, opcode}, {26'b0, ir[31:26]});
        chk({tag, ".pc"}, instr_pc, pc);
    endtask

    initial begin
        // ---- reset ----
        #1 rst_n = 1'b0;
        tick(); tick();
        chk("rst.req", {31'b0, imem_req}, 32'd0);
        chk("rst.addr", imem_addr, 32'h0);
        chk("rst.valid", {31'b0, instr_valid}, 32'd0);
        chk("rst.instr", instr, 32'h0);
        chk("rst.opcode", {26'b0, opcode}, 32'h0);
        chk("rst.pc", instr_pc, 32'h0);
        rst_n = 1'b1;

        // ---- first fetch at 0, 1-cycle memory ----
        tick();                                  // S_IDLE -> S_REQ
        chk_req("f0", 32'h0);
        imem_gnt = 1'b1;
        tick();                                  // -> S_WAIT
        chk("f0.wait_req", {31'b0, imem_req}, 32'd0);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h8C22_0004;
        tick();                                  // -> S_HOLD
        imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        chk_hold("f0", 32'h8C22_0004, 32'h0);
        chk("f0.opc_lw", {26'b0, opcode}, 32'h23);

        // ---- stall: ready low for 10 cycles ----
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_hold("stall", 32'h8C22_0004, 32'h0);
        end

        instr_ready = 1'b1;
        tick();                                  // handshake -> S_REQ at 4
        instr_ready = 1'b0;
        chk_req("f1", 32'h4);

        // ---- fetch at 4 ----
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2001_0005;
        tick();
        imem_rvalid = 1'b0;
        chk_hold("f1", 32'h2001_0005, 32'h4);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk_req("f2", 32'h8);

        // ---- gnt withheld at 8, redirect to 0x40 in cycle 2 ----
        tick();
        chk_req("nogt1", 32'h8);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk_req("nogt2", 32'h40);
        tick();
        chk_req("nogt3", 32'h40);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("nogt.wait_req", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hAC43_0008;
        tick();
        imem_rvalid = 1'b0;
        chk_hold("f40", 32'hAC43_0008, 32'h40);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk_req("f44", 32'h44);

        // ---- redirect in S_WAIT, late response discarded ----
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();                                  // -> S_FLUSH
        redirect_valid = 1'b0;
        chk("fl.req", {31'b0, imem_req}, 32'd0);
        chk("fl.valid", {31'b0, instr_valid}, 32'd0);
        tick();
        chk("fl.req2", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h1000_0003;
        tick();                                  // response dropped -> S_REQ
        imem_rvalid = 1'b0;
        chk_req("fl.next", 32'h100);
        chk("fl.ir_kept", instr, 32'hAC43_0008);

        // ---- redirect beats ready in S_HOLD, unaligned target ----
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0800_0010;
        tick();
        imem_rvalid = 1'b0;
        chk_hold("f100", 32'h0800_0010, 32'h100);
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h203;
        tick();
        instr_ready = 1'b0; redirect_valid = 1'b0;
        chk_req("rdprio", 32'h200);

        // ---- redirect and rvalid together in S_WAIT ----
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        imem_rvalid = 1'b0; redirect_valid = 1'b0;
        chk_req("rdrv", 32'h300);
        chk("rdrv.ir_kept", instr, 32'h0800_0010);

        // ---- PC wrap at top of address space ----
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk_req("wrap.req", 32'hFFFF_FFFC);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3C01_1234;
        tick();
        imem_rvalid = 1'b0;
        chk_hold("wrap", 32'h3C01_1234, 32'hFFFF_FFFC);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk_req("wrap.next", 32'h0);

        // ---- redirect together with grant -> S_FLUSH ----
        imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        imem_gnt = 1'b0; redirect_valid = 1'b0;
        chk("rg.req", {31'b0, imem_req}, 32'd0);
        chk("rg.addr", imem_addr, 32'h80);
        imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
        tick();
        imem_rvalid = 1'b0;
        chk_req("rg.next", 32'h80);
        chk("rg.ir_kept", instr, 32'h3C01_1234);

`ifdef IFU_PERF_CNT_EN
        chk("perf.fetch", fetch_count, 32'd4);
        chk("perf.flush", flush_count, 32'd6);
`endif

        // ---- asynchronous reset pulse while in S_WAIT ----
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("ar.wait_req", {31'b0, imem_req}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.req", {31'b0, imem_req}, 32'd0);
        chk("ar.addr", imem_addr, 32'h0);
        chk("ar.valid", {31'b0, instr_valid}, 32'd0);
        chk("ar.instr", instr, 32'h0);
        chk("ar.opcode", {26'b0, opcode}, 32'h0);
        chk("ar.pc", instr_pc, 32'h0);
`ifdef IFU_PERF_CNT_EN
        chk("ar.fetch_cnt", fetch_count, 32'd0);
        chk("ar.flush_cnt", flush_count, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        chk_req("ar.restart", 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
